// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode definitions: canonical NOP, zero word,
// RV32I major opcodes and the fetch-to-decode bundle.
package if_id_buf_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } if_id_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer with push/pop/flush,
// occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush drops everything by snapping the read side onto the write side.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// Elastic fetch-to-decode register: buffered instruction/PC pairs,
// NOP presented to decode whenever nothing valid is held.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = INST_NOP,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   inst_i,
  input  logic [31:0]   inst_addr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [31:0]   inst_o,
  output logic [31:0]   inst_addr_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  input  logic          jump_en_i,
  output logic [CW-1:0] occupancy_o
);

  if_id_t wr_entry;
  if_id_t head;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;

  assign wr_entry.inst = inst_i;
  assign wr_entry.addr = inst_addr_i;

  // Ready comes from the count register only: no ready path through.
  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  sync_fifo #(
    .WIDTH ($bits(if_id_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_en_i),
    .wdata (wr_entry),
    .rdata (head),
    .count (occupancy_o),
    .full  (full),
    .empty (empty)
  );

  assign inst_o      = out_valid_o ? head.inst : NOP_INST;
  assign inst_addr_o = out_valid_o ? head.addr : ZERO_WORD;

endmodule

// File: tb/tb_if_id_buf.sv
// Table-driven directed vectors plus a queue scoreboard that
// follows every accepted instruction through to decode.
module tb_if_id_buf;
  import if_id_buf_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] IJ  = 32'h0050_0293;
  localparam logic [31:0] IR  = 32'h0060_0313;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        jump_en_i;
  logic [1:0]  occupancy_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_t sb_q[$];

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        ordy;
    logic        jmp;
    logic        chk;
    logic        ov;
    logic [31:0] einst;
    logic [31:0] eaddr;
    logic        ir;
    logic [1:0]  occ;
  } vec_t;

  vec_t vecs[30];

  always #5 clk = ~clk;

  if_id_buf #(.DEPTH(2), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .jump_en_i   (jump_en_i),
    .occupancy_o (occupancy_o)
  );

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [31:0] ins,
    input logic [31:0] a, input logic ordy, input logic j,
    input logic c, input logic ov, input logic [31:0] ei,
    input logic [31:0] ea, input logic ir, input logic [1:0] occ);
    vec_t v;
    v.rst = r;  v.iv = iv; v.inst = ins; v.addr = a;
    v.ordy = ordy; v.jmp = j; v.chk = c; v.ov = ov;
    v.einst = ei; v.eaddr = ea; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  // Scoreboard: acceptance and consumption both resolve at the next edge.
  always @(negedge clk) begin
    if (rst === 1'b1 || jump_en_i === 1'b1) begin
      sb_q.delete();
    end else begin
      check("sb_valid", sb_q.size(), 64'(out_valid_o),
            64'(sb_q.size() != 0));
      if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious", 0, {inst_o, inst_addr_o}, 64'hx);
        end else begin
          check("sb_data", sb_q.size(), {inst_o, inst_addr_o},
                sb_q.pop_front());
        end
      end
      if (in_valid_i === 1'b1 && in_ready_o === 1'b1)
        sb_q.push_back('{inst: inst_i, addr: inst_addr_i});
    end
  end

  initial begin
    // rst iv inst addr ordy jmp | chk ov einst eaddr ir occ
    vecs[0]  = mk(1, 0, 0,  0,     0, 0, 0, 0, NOP, 0,     1, 0);
    vecs[1]  = mk(1, 0, 0,  0,     0, 0, 1, 0, NOP, 0,     1, 0);
    vecs[2]  = mk(0, 0, 0,  0,     1, 0, 1, 0, NOP, 0,     1, 0);
    vecs[3]  = mk(0, 1, 32'h00500093, 0, 1, 0, 1, 0, NOP, 0, 1, 0);
    vecs[4]  = mk(0, 1, 32'h00108113, 4, 1, 0,
                  1, 1, 32'h00500093, 0, 1, 1);
    vecs[5]  = mk(0, 1, 32'h002081B3, 8, 1, 0,
                  1, 1, 32'h00108113, 4, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 32'h002081B3, 8, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 1, 0, NOP, 0, 1, 0);
    vecs[8]  = mk(0, 1, I0, 0, 0, 0, 1, 0, NOP, 0, 1, 0);
    vecs[9]  = mk(0, 1, I1, 4, 0, 0, 1, 1, I0,  0, 1, 1);
    vecs[10] = mk(0, 1, I2, 8, 0, 0, 1, 1, I0,  0, 0, 2);
    vecs[11] = mk(0, 1, I2, 8, 1, 0, 1, 1, I0,  0, 0, 2);
    vecs[12] = mk(0, 1, I2, 8, 0, 0, 1, 1, I1,  4, 1, 1);
    vecs[13] = mk(0, 1, I3, 12, 1, 0, 1, 1, I1, 4, 0, 2);
    vecs[14] = mk(0, 1, I3, 12, 1, 0, 1, 1, I2, 8, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 0, 1, 1, I3, 12, 1, 1);
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 1, 0, NOP, 0, 1, 0);
    vecs[17] = mk(0, 1, I0, 0, 0, 0, 1, 0, NOP, 0, 1, 0);
    vecs[18] = mk(0, 1, I1, 4, 0, 0, 1, 1, I0,  0, 1, 1);
    vecs[19] = mk(0, 1, IJ, 16, 1, 1, 1, 1, I0, 0, 0, 2);
    vecs[20] = mk(0, 0, 0, 0, 1, 0, 1, 0, NOP, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 1, 0, NOP, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 1, 0, 1, 0, NOP, 0, 1, 0);
    vecs[23] = mk(0, 1, I0, 0, 0, 0, 1, 0, NOP, 0, 1, 0);
    vecs[24] = mk(0, 1, I1, 4, 0, 0, 1, 1, I0,  0, 1, 1);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 1, 1, I0,  0, 0, 2);
    vecs[26] = mk(0, 1, IR, 32'h100, 0, 0, 1, 0, NOP, 0, 1, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 1, 1, IR, 32'h100, 1, 1);
    vecs[28] = mk(0, 0, 0, 0, 1, 0, 1, 1, IR, 32'h100, 1, 1);
    vecs[29] = mk(0, 0, 0, 0, 1, 0, 1, 0, NOP, 0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      rst         = vecs[i].rst;
      in_valid_i  = vecs[i].iv;
      inst_i      = vecs[i].inst;
      inst_addr_i = vecs[i].addr;
      out_ready_i = vecs[i].ordy;
      jump_en_i   = vecs[i].jmp;
      @(negedge clk);
      if (vecs[i].chk) begin
        check("out_valid", i, 64'(out_valid_o), 64'(vecs[i].ov));
        check("inst", i, 64'(inst_o), 64'(vecs[i].einst));
        check("inst_addr", i, 64'(inst_addr_o), 64'(vecs[i].eaddr));
        check("in_ready", i, 64'(in_ready_o), 64'(vecs[i].ir));
        check("occupancy", i, 64'(occupancy_o), 64'(vecs[i].occ));
      end
      @(posedge clk);
      #1;
    end

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      rst         = 1'b0;
      in_valid_i  = ($urandom_range(0, 3) != 0);
      inst_i      = $urandom;
      inst_addr_i = 32'(i) << 2;
      out_ready_i = ($urandom_range(0, 2) != 0);
      jump_en_i   = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end

    in_valid_i  = 1'b0;
    jump_en_i   = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_queue", 0, 64'(sb_q.size()), 64'd0);
    check("drain_valid", 0, 64'(out_valid_o), 64'd0);
    check("drain_inst", 0, 64'(inst_o), 64'(NOP));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
